// File: rtl/amcp_send_arb_pkg.sv
// amcp_pkg: shared types and constants for the MCP send arbiter slice.
//   arb_state_e : arbiter FSM encoding
//   DW_DEF      : default data word width (matches the sender adatain)
//   idx_w()     : index width for an N-entry requester vector (min 1 bit)
package amcp_pkg;

    localparam int unsigned DW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_ACK = 2'd2
    } arb_state_e;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/amcp_send_arb_if.sv
// amcp_send_arb_if: requester-side and sender-side handshake bundle.
//   req_valid [N]    : per-requester word valid (level)
//   req_data  [N*DW] : packed words, requester i at [i*DW +: DW]
//   req_ready [N]    : one-hot capture pulse back to the requesters
//   snd_ready        : sender aready
//   snd_data  [DW]   : sender adatain
//   snd_send         : sender asend
// master = arbiter view, slave = producers/sender view.
interface amcp_send_arb_if
    import amcp_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = DW_DEF
);

    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            snd_ready;
    logic [DW-1:0]   snd_data;
    logic            snd_send;

    modport master (
        input  req_valid, req_data, snd_ready,
        output req_ready, snd_data, snd_send
    );

    modport slave (
        output req_valid, req_data, snd_ready,
        input  req_ready, snd_data, snd_send
    );

endinterface

// File: rtl/amcp_send_arb_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req  [N]  : request vector
//   last [IW] : index of the previous winner (search starts just after it)
//   gnt  [N]  : one-hot winner, zero when nothing requested
//   idx  [IW] : winner index
//   any       : at least one request present
module rr_pick
    import amcp_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] pos;

    // Offsets 1..N from the last winner; offset N is the last winner itself,
    // so a requester that just won is considered last.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = 1; k <= int'(N); k++) begin
            pos = IW'((int'(last) + k) % int'(N));
            if (!any && req[pos]) begin
                any      = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/amcp_send_arb.sv
// amcp_send_arb: round-robin arbiter sharing one MCP-formulation sender
// among N aclk-domain requesters. Captures the granted word, drives the
// sender's adatain/asend, then waits for aready to return (receive-side ack).
//   aclk, arst_n : clock, async active-low reset
//   bus          : amcp_send_arb_if master (requester + sender handshakes)
//   err_clr      : pulse, clears tmo_err
//   grant_id     : index of last granted requester
//   busy         : FSM not in IDLE
//   tmo_err      : sticky ack-timeout flag
//   sent_cnt     : words accepted by the sender, wrapping
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | arbitrate; grant only while the sender is ready
// SEND     | asend high, word held until the sender accepts it
// WAIT_ACK | wait for aready to return; timeout counter running
module amcp_send_arb
    import amcp_pkg::*;
#(
    parameter  int unsigned N     = 4,
    parameter  int unsigned DW    = DW_DEF,
    parameter  int unsigned TMO_W = 8,
    parameter  int unsigned CNT_W = 16,
    localparam int unsigned IW    = idx_w(N)
) (
    input  logic              aclk,
    input  logic              arst_n,
    amcp_send_arb_if.master   bus,
    input  logic              err_clr,
    output logic [IW-1:0]     grant_id,
    output logic              busy,
    output logic              tmo_err,
    output logic [CNT_W-1:0]  sent_cnt
);

    localparam logic [TMO_W-1:0] TMO_PRE = {{(TMO_W-1){1'b1}}, 1'b0};

    arb_state_e       state_q, state_d;
    logic [DW-1:0]    snd_data_q, snd_data_d;
    logic             snd_send_q, snd_send_d;
    logic [IW-1:0]    grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    logic [N-1:0]     req_ready_c;

    logic [N-1:0]     pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req  (bus.req_valid),
        .last (grant_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= IDLE;
            snd_data_q <= '0;
            snd_send_q <= 1'b0;
            grant_q    <= IW'(N - 1);
            cnt_q      <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            snd_data_q <= snd_data_d;
            snd_send_q <= snd_send_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        snd_data_d  = snd_data_q;
        snd_send_d  = snd_send_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        err_d       = err_q;
        req_ready_c = '0;

        if (err_clr) begin
            err_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (pick_any && bus.snd_ready) begin
                    req_ready_c = pick_gnt;
                    snd_data_d  = bus.req_data[int'(pick_idx)*DW +: DW];
                    grant_d     = pick_idx;
                    snd_send_d  = 1'b1;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (snd_send_q && bus.snd_ready) begin
                    snd_send_d = 1'b0;
                    cnt_d      = cnt_q + 1'b1;
                    tmo_d      = '0;
                    state_d    = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (tmo_q != '1) begin
                    tmo_d = tmo_q + 1'b1;
                end
                // Set on the step into all-ones; overrides a same-cycle clear.
                if (tmo_q == TMO_PRE) begin
                    err_d = 1'b1;
                end
                // tmo_q == 0 only in the first WAIT_ACK cycle, where aready
                // may still be high from the accept.
                if (tmo_q != '0 && bus.snd_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.req_ready = req_ready_c;
    assign bus.snd_data  = snd_data_q;
    assign bus.snd_send  = snd_send_q;
    assign grant_id      = grant_q;
    assign busy          = (state_q != IDLE);
    assign tmo_err       = err_q;
    assign sent_cnt      = cnt_q;

endmodule

// File: tb/tb_amcp_send_arb.sv
// tb_amcp_send_arb: directed bench for amcp_send_arb with a scoreboard.
// Stimulus pushes hand-ordered expected (id, data) pairs; a monitor pops
// and compares each time the sender accepts a word. Requester and sender
// behaviour are modelled by separate processes.
// The counter width is narrowed so the wrap can be reached in a short run.
module tb_amcp_send_arb;
    import amcp_pkg::*;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int TMO_W = 8;
    localparam int CNT_W = 8;

    logic             aclk    = 1'b0;
    logic             arst_n  = 1'b0;
    logic             err_clr = 1'b0;
    logic [1:0]       grant_id;
    logic             busy;
    logic             tmo_err;
    logic [CNT_W-1:0] sent_cnt;

    amcp_send_arb_if #(.N(N), .DW(DW)) bus ();

    amcp_send_arb #(.N(N), .DW(DW), .TMO_W(TMO_W), .CNT_W(CNT_W)) dut (
        .aclk     (aclk),
        .arst_n   (arst_n),
        .bus      (bus),
        .err_clr  (err_clr),
        .grant_id (grant_id),
        .busy     (busy),
        .tmo_err  (tmo_err),
        .sent_cnt (sent_cnt)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    int         checks  = 0;
    int         errs    = 0;
    int         ack_dly = 1;
    bit         snd_hold = 1'b0;
    exp_t       exq[$];
    logic [7:0] rq[N][$];
    logic [N-1:0] rr;
    exp_t       mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errs++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [7:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        exq.push_back(e);
    endtask

    function automatic bit rq_empty();
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_req(input string name);
        int n = 0;
        while (bus.req_ready == '0 && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (bus.req_ready == '0) fail_timeout(name);
    endtask

    task automatic wait_done(input string name, input int lim);
        int n = 0;
        while (!(exq.size() == 0 && !busy && rq_empty()) && n < lim) begin
            @(negedge aclk);
            n++;
        end
        if (!(exq.size() == 0 && !busy && rq_empty())) fail_timeout(name);
    endtask

    // Requesters: hold each queued word until its req_ready pulse, then present the next.
    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        forever begin
            @(negedge aclk);
            rr = bus.req_ready;
            @(posedge aclk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (rr[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                bus.req_valid[i]         = (rq[i].size() > 0);
                bus.req_data[i*DW +: DW] = (rq[i].size() > 0) ? rq[i][0] : 8'h3C;
            end
        end
    end

    // Sender: drops aready after an accept, returns it after ack_dly cycles.
    initial begin
        bus.snd_ready = 1'b1;
        forever begin
            @(negedge aclk);
            if (arst_n && bus.snd_send && bus.snd_ready) begin
                @(posedge aclk);
                #1;
                bus.snd_ready = 1'b0;
                for (int k = 0; k < ack_dly; k++) begin
                    @(posedge aclk);
                    #1;
                end
                while (snd_hold) begin
                    @(posedge aclk);
                    #1;
                end
                bus.snd_ready = 1'b1;
            end
        end
    end

    // Monitor
    always @(negedge aclk) begin
        if (bus.req_ready != '0) begin
            check("req_ready_onehot", 32'($onehot(bus.req_ready)), 32'd1);
            check("req_ready_not_busy", 32'(busy), 32'd0);
        end
        if (arst_n && bus.snd_send && bus.snd_ready) begin
            if (exq.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_send: got data 0x%0h id %0d, want no send", bus.snd_data, grant_id);
            end else begin
                mon_e = exq.pop_front();
                check("sb_snd_data", 32'(bus.snd_data), 32'(mon_e.data));
                check("sb_grant_id", 32'(grant_id), 32'(mon_e.id));
            end
        end
    end

    initial begin
        int n;
        int cnt;
        logic [7:0] d;

        arst_n = 1'b0;
        repeat (3) @(negedge aclk);
        check("rst_grant_id", 32'(grant_id), 32'd3);
        check("rst_snd_send", 32'(bus.snd_send), 32'd0);
        check("rst_snd_data", 32'(bus.snd_data), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tmo_err", 32'(tmo_err), 32'd0);
        check("rst_sent_cnt", 32'(sent_cnt), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        arst_n = 1'b1;
        @(negedge aclk);

        // single word, grant latency
        rq[0].push_back(8'hA5);
        push_exp(2'd0, 8'hA5);
        wait_req("t1_req_wait");
        check("t1_req_ready", 32'(bus.req_ready), 32'b0001);
        check("t1_send_not_yet", 32'(bus.snd_send), 32'd0);
        @(negedge aclk);
        check("t1_snd_send", 32'(bus.snd_send), 32'd1);
        check("t1_snd_data", 32'(bus.snd_data), 32'hA5);
        wait_done("t1_done", 40);
        check("t1_sent_cnt", 32'(sent_cnt), 32'd1);

        arst_n = 1'b0;
        @(negedge aclk);
        arst_n = 1'b1;
        @(negedge aclk);

        // all four requesting, slow ack: order 0,1,2,3,0
        ack_dly = 3;
        rq[0].push_back(8'h10);
        rq[0].push_back(8'h14);
        rq[1].push_back(8'h11);
        rq[2].push_back(8'h12);
        rq[3].push_back(8'h13);
        push_exp(2'd0, 8'h10);
        push_exp(2'd1, 8'h11);
        push_exp(2'd2, 8'h12);
        push_exp(2'd3, 8'h13);
        push_exp(2'd0, 8'h14);
        wait_done("t2_done", 200);
        check("t2_sent_cnt", 32'(sent_cnt), 32'd5);
        check("t2_grant_id", 32'(grant_id), 32'd0);

        // grant 2 in flight, then 0101 -> 0 (wrap) then 2
        rq[2].push_back(8'h22);
        push_exp(2'd2, 8'h22);
        wait_req("t3_req_wait");
        check("t3_req_ready", 32'(bus.req_ready), 32'b0100);
        rq[0].push_back(8'h20);
        rq[2].push_back(8'h23);
        push_exp(2'd0, 8'h20);
        push_exp(2'd2, 8'h23);
        wait_done("t3_done", 100);
        check("t3_grant_id", 32'(grant_id), 32'd2);
        check("t3_sent_cnt", 32'(sent_cnt), 32'd8);

        // ack timeout; err_clr in the set cycle loses
        ack_dly  = 1;
        snd_hold = 1'b1;
        rq[1].push_back(8'h5A);
        push_exp(2'd1, 8'h5A);
        n = 0;
        while (!bus.snd_send && n < 50) begin
            @(negedge aclk);
            n++;
        end
        while (bus.snd_send && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 50) fail_timeout("t4_accept_wait");
        cnt = 0;
        while (!tmo_err && cnt < 400) begin
            err_clr = (cnt == 254);
            @(negedge aclk);
            cnt++;
        end
        err_clr = 1'b0;
        check("t4_tmo_cycles", 32'(cnt), 32'd255);
        check("t4_tmo_err", 32'(tmo_err), 32'd1);
        check("t4_busy", 32'(busy), 32'd1);
        repeat (5) @(negedge aclk);
        check("t4_busy_held", 32'(busy), 32'd1);
        snd_hold = 1'b0;
        wait_done("t4_done", 20);
        check("t4_idle", 32'(busy), 32'd0);
        check("t4_tmo_sticky", 32'(tmo_err), 32'd1);
        err_clr = 1'b1;
        @(negedge aclk);
        err_clr = 1'b0;
        check("t4_tmo_cleared", 32'(tmo_err), 32'd0);
        check("t4_sent_cnt", 32'(sent_cnt), 32'd9);

        // reset during SEND; word abandoned, requester 0 first afterwards
        rq[3].push_back(8'h77);
        wait_req("t5_req_wait");
        check("t5_req_ready", 32'(bus.req_ready), 32'b1000);
        @(posedge aclk);
        #1;
        check("t5_in_send", 32'(bus.snd_send), 32'd1);
        arst_n = 1'b0;
        #1;
        check("t5_rst_snd_send", 32'(bus.snd_send), 32'd0);
        check("t5_rst_grant_id", 32'(grant_id), 32'd3);
        check("t5_rst_sent_cnt", 32'(sent_cnt), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        @(negedge aclk);
        arst_n = 1'b1;
        @(negedge aclk);
        rq[0].push_back(8'h01);
        rq[1].push_back(8'h02);
        rq[3].push_back(8'h03);
        push_exp(2'd0, 8'h01);
        push_exp(2'd1, 8'h02);
        push_exp(2'd3, 8'h03);
        wait_req("t5_req0_wait");
        check("t5_req0_first", 32'(bus.req_ready), 32'b0001);
        wait_done("t5_done", 100);
        check("t5_sent_cnt", 32'(sent_cnt), 32'd3);

        // counter wrap at full rate; requester data changes right after capture
        ack_dly = 0;
        for (int i = 0; i < 253; i++) begin
            d = 8'(i) ^ 8'h5C;
            rq[0].push_back(d);
            push_exp(2'd0, d);
        end
        wait_done("t6_done", 3000);
        check("t6_sent_cnt_wrap", 32'(sent_cnt), 32'd0);
        rq[2].push_back(8'hE7);
        push_exp(2'd2, 8'hE7);
        wait_done("t6_after_wrap", 40);
        check("t6_sent_cnt_one", 32'(sent_cnt), 32'd1);
        check("t6_snd_data_hold", 32'(bus.snd_data), 32'hE7);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
